xbar_slave_arbiter: RTL and testbench

Per-slave-port arbiter for the N×N crossbar. Decodes which masters target this slave from their address MSBs and grants one of them round-robin. Steers the granted master's request onto the slave port and routes the slave's ack/resp/rdata back. Holds the grant until the transaction's response returns. One instance per slave port; the crossbar top instantiates N of them with SLAVE_ID = 0..N-1.

---
 rtl/xbar_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/xbar_slave_arbiter.sv | 115 +++++++++++
 tb/tb_xbar_slave_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar arbiters.
// Command encoding, arbiter FSM states and the slave-select width function.
package xbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set elig bit scanning ptr, ptr+1, ... mod N.
// Latency: purely combinational.
// Backpressure: none; callers decide when to consume the pick.
module rr_pick
    import xbar_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = sel_width(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // N is a power of two, so W-bit wraparound gives the modulo for free.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!valid && elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port round-robin arbiter: steers one master onto the slave, returns ack/resp/rdata.
// Latency: one registered arbitration cycle from m_req to s_req; ack/resp paths are combinational.
// Backpressure: grant held until the slave responds; others wait with req asserted.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int SLAVE_ID = 0,
    localparam int SW       = sel_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      m_req,
    input  logic [N-1:0]      m_cmd,
    input  logic [31:0]       m_addr  [N],
    input  logic [31:0]       m_wdata [N],
    output logic [N-1:0]      m_ack,
    output logic [N-1:0]      m_resp,
    output logic [31:0]       m_rdata,
    output logic              s_req,
    output logic              s_cmd,
    output logic [31-SW:0]    s_addr,
    output logic [31:0]       s_wdata,
    input  logic              s_ack,
    input  logic              s_resp,
    input  logic [31:0]       s_rdata
);

    localparam logic [SW-1:0] SID = SW'(SLAVE_ID);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] g, g_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  elig;
    logic          pick_vld;
    logic [SW-1:0] pick_idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = m_req[i] && (m_addr[i][31 -: SW] == SID);
        end
    end

    rr_pick #(.N(N)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        s_req     = 1'b0;
        s_cmd     = CMD_READ;
        s_addr    = '0;
        s_wdata   = '0;
        m_ack     = '0;
        m_resp    = '0;
        m_rdata   = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    g_nxt     = pick_idx;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                m_rdata = s_rdata;
                // A master withdrawing before ack forfeits the slot without advancing ptr.
                if (m_req[g]) begin
                    s_req     = 1'b1;
                    s_cmd     = m_cmd[g];
                    s_addr    = m_addr[g][31-SW:0];
                    s_wdata   = m_wdata[g];
                    m_ack[g]  = s_ack;
                    m_resp[g] = s_ack && s_resp;
                    if (s_ack) begin
                        if (s_resp) begin
                            state_nxt = IDLE;
                            ptr_nxt   = g + 1'b1;
                        end else begin
                            state_nxt = RESP;
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                m_rdata   = s_rdata;
                m_resp[g] = s_resp;
                if (s_resp) begin
                    state_nxt = IDLE;
                    ptr_nxt   = g + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter (N=4, SLAVE_ID=0).
module tb_xbar_slave_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m_req;
    logic [3:0]  m_cmd;
    logic [31:0] m_addr  [4];
    logic [31:0] m_wdata [4];
    logic [3:0]  m_ack;
    logic [3:0]  m_resp;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_cmd;
    logic [29:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic        s_resp;
    logic [31:0] s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter #(.N(4), .SLAVE_ID(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_cmd   (m_cmd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_resp  (m_resp),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_cmd   (s_cmd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_resp  (s_resp),
        .s_rdata (s_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks run 3 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sreq"},  {31'd0, s_req}, 32'd0);
        chk({tag, "_mack"},  {28'd0, m_ack}, 32'd0);
        chk({tag, "_mresp"}, {28'd0, m_resp}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        m_cmd   = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i]  = 32'(i) * 32'h100;
            m_wdata[i] = 32'hA000_0000 + 32'(i);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        settle();
        chk_quiet("reset");
        chk("reset_rdata", m_rdata, 32'd0);
        chk("reset_saddr", {2'b00, s_addr}, 32'd0);

        // 1: single read from master 1
        m_req = 4'b0010; m_addr[1] = 32'h0000_0010; m_cmd[1] = 1'b0;
        settle();
        chk("t1_arb_sreq", {31'd0, s_req}, 32'd0);
        cyc();
        s_ack = 1'b1;
        settle();
        chk("t1_sreq", {31'd0, s_req}, 32'd1);
        chk("t1_saddr", {2'b00, s_addr}, 32'h10);
        chk("t1_scmd", {31'd0, s_cmd}, 32'd0);
        chk("t1_mack", {28'd0, m_ack}, 32'b0010);
        chk("t1_mresp_early", {28'd0, m_resp}, 32'd0);
        cyc();
        m_req = '0; s_ack = 1'b0;
        settle();
        chk_quiet("t1_wait");
        cyc();
        s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_mresp", {28'd0, m_resp}, 32'b0010);
        chk("t1_rdata", m_rdata, 32'hDEAD_BEEF);
        cyc();
        s_resp = 1'b0;
        settle();
        chk("t1_idle_rdata", m_rdata, 32'd0);
        chk_quiet("t1_idle");

        // 2: all masters contend after a fresh reset; expect 0,1,2,3,0
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_addr[i] = 32'(i) * 32'h4;
        m_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            settle();
            chk("t2_idle_sreq", {31'd0, s_req}, 32'd0);
            cyc();
            s_ack = 1'b1;
            settle();
            chk("t2_grant_addr", {2'b00, s_addr}, 32'(t % 4) * 32'h4);
            chk("t2_mack_onehot", {28'd0, m_ack}, 32'd1 << (t % 4));
            cyc();
            s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'(t);
            settle();
            chk("t2_mresp", {28'd0, m_resp}, 32'd1 << (t % 4));
            chk("t2_mack_off", {28'd0, m_ack}, 32'd0);
            chk("t2_rdata", m_rdata, 32'(t));
            cyc();
            s_resp = 1'b0;
        end
        m_req = '0;

        // 3: request addressed to slave 2 must be ignored
        m_addr[2] = 32'h8000_0000;
        m_req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            settle();
            chk("t3_sreq", {31'd0, s_req}, 32'd0);
            chk("t3_mack", {28'd0, m_ack}, 32'd0);
            cyc();
        end
        m_req = '0;
        m_addr[2] = 32'h0000_0200;
        cyc();

        // 4: write from master 3 with same-cycle ack+resp
        m_req = 4'b1000; m_cmd[3] = 1'b1;
        m_addr[3] = 32'h0000_0004; m_wdata[3] = 32'h1234_5678;
        cyc();
        s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h0;
        settle();
        chk("t4_wdata", s_wdata, 32'h1234_5678);
        chk("t4_scmd", {31'd0, s_cmd}, 32'd1);
        chk("t4_saddr", {2'b00, s_addr}, 32'h4);
        chk("t4_mack", {28'd0, m_ack}, 32'b1000);
        chk("t4_mresp", {28'd0, m_resp}, 32'b1000);
        cyc();
        m_req = '0; s_ack = 1'b0; s_resp = 1'b0; m_cmd[3] = 1'b0;
        cyc();
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0110;
        m_req = 4'b0011;
        cyc();
        s_ack = 1'b1; s_resp = 1'b1;
        settle();
        chk("t4_ptr0_grant", {2'b00, s_addr}, 32'h100);
        chk("t4_ptr0_mack", {28'd0, m_ack}, 32'b0001);
        cyc();
        m_req = '0; s_ack = 1'b0; s_resp = 1'b0;
        cyc();

        // 5: master 2 withdraws before ack, then wins again ahead of master 3
        m_addr[2] = 32'h0000_0200; m_addr[3] = 32'h0000_0300;
        m_req = 4'b1100;
        cyc();
        settle();
        chk("t5_grant2", {2'b00, s_addr}, 32'h200);
        cyc();
        m_req = 4'b1000;
        settle();
        chk("t5_drop_sreq", {31'd0, s_req}, 32'd0);
        chk("t5_drop_mack", {28'd0, m_ack}, 32'd0);
        cyc();
        m_req = 4'b1100;
        settle();
        chk("t5_idle_sreq", {31'd0, s_req}, 32'd0);
        cyc();
        s_ack = 1'b1;
        settle();
        chk("t5_regrant2", {2'b00, s_addr}, 32'h200);
        chk("t5_mack2", {28'd0, m_ack}, 32'b0100);
        cyc();

        // 6: reset while waiting in RESP
        m_req = '0; s_ack = 1'b0; s_rdata = 32'hCAFE_F00D;
        settle();
        chk("t6_resp_rdata", m_rdata, 32'hCAFE_F00D);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; s_resp = 1'b1; s_rdata = 32'h0000_0055;
        settle();
        chk_quiet("t6_after_rst");
        chk("t6_rdata", m_rdata, 32'd0);
        chk("t6_saddr", {2'b00, s_addr}, 32'd0);
        chk("t6_swdata", s_wdata, 32'd0);
        chk("t6_scmd", {31'd0, s_cmd}, 32'd0);
        cyc();
        s_resp = 1'b0;
        m_req = 4'b0011;
        cyc();
        settle();
        chk("t6_ptr_reset_grant", {2'b00, s_addr}, 32'h100);
        chk("t6_sreq", {31'd0, s_req}, 32'd1);
        m_req = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
